fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one FIFO write port among NUM_REQ producers.
- Each producer owns the port for a burst of up to BURST_MAX words, or until it marks a last word.
- Sits directly in front of the FIFO. Drives its wr_en/din and obeys its full flag.
- Requesters see a per-word grant, i.e. a valid/ack handshake.

---
 rtl/fifo_wr_arbiter_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 89 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_t;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int b);
      return $clog2(b + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first set req after ptr, wrapping; rotate, priority-encode, un-rotate.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               valid,
   output logic [ID_W-1:0]    winner
);

   logic [NUM_REQ-1:0] rot;
   int base;
   int off;

   always_comb begin
      base = (int'(ptr) + 1) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++)
         rot[i] = req[ID_W'((base + i) % NUM_REQ)];
      off   = 0;
      valid = 1'b0;
      // descending scan so the lowest rotated index is the one left standing
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off   = i;
            valid = 1'b1;
         end
      end
      winner = ID_W'((base + off) % NUM_REQ);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_MAX  = 4,
   localparam int ID_W      = id_w(NUM_REQ),
   localparam int CNT_W     = cnt_w(BURST_MAX)
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic [ID_W-1:0]               owner_id,
   output logic                          busy
);

   arb_state_t state, state_nx;
   logic [ID_W-1:0]       rr_ptr;
   logic [CNT_W-1:0]      beat_cnt;
   logic [DATA_WIDTH-1:0] lane [NUM_REQ];

   logic            own, cur_req, cur_last, xfer, burst_end, rel, load;
   logic            pick_valid;
   logic [ID_W-1:0] pick_id;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign lane[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // rr_ptr tracks owner_id while in OWN, so one pointer serves both cases
   rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .valid  (pick_valid),
      .winner (pick_id)
   );

   assign own       = (state == OWN);
   assign cur_req   = req[owner_id];
   assign cur_last  = req_last[owner_id];
   assign xfer      = own && cur_req && !fifo_full;
   assign burst_end = (beat_cnt == CNT_W'(BURST_MAX - 1));
   assign rel       = own && ((xfer && (cur_last || burst_end)) || !cur_req);
   assign load      = (!own || rel) && pick_valid;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_valid) state_nx = OWN;
         OWN:     if (rel)        state_nx = pick_valid ? OWN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy       = own;
      fifo_wr_en = xfer;
      fifo_din   = xfer ? lane[owner_id] : '0;
      gnt        = '0;
      if (xfer) gnt[owner_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         rr_ptr   <= ID_W'(NUM_REQ - 1);
         owner_id <= '0;
         beat_cnt <= '0;
      end else if (load) begin
         rr_ptr   <= pick_id;
         owner_id <= pick_id;
         beat_cnt <= '0;
      end else if (xfer) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus random checks of fifo_wr_arbiter against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BM = 4;

   logic          clk = 1'b0;
   logic          rst_;
   logic [N-1:0]  req, req_last, gnt;
   logic [N*DW-1:0] req_data;
   logic          fifo_full, fifo_wr_en, busy;
   logic [DW-1:0] fifo_din;
   logic [1:0]    owner_id;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst_(rst_), .req(req), .req_data(req_data), .req_last(req_last),
      .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .owner_id(owner_id), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   bit m_own;
   int m_owner, m_ptr, m_beats;
   int wr_cnt;
   int lane_cnt [N];
   int gnt_log [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] lane_of(input int i);
      return req_data[i*DW +: DW];
   endfunction

   task automatic set_lane(input int i, input bit r, input logic [DW-1:0] d, input bit l);
      req[i] = r;
      req_data[i*DW +: DW] = d;
      req_last[i] = l;
   endtask

   task automatic clear_counts();
      wr_cnt = 0;
      for (int i = 0; i < N; i++) lane_cnt[i] = 0;
      gnt_log.delete();
   endtask

   // one clock: check outputs mid-cycle, then advance the model at the edge
   task automatic cycle();
      bit x, rel;
      logic [N-1:0]  eg;
      logic [DW-1:0] ed;
      int c;
      @(negedge clk);
      x  = m_own && req[m_owner] && !fifo_full;
      eg = '0;
      if (x) eg[m_owner] = 1'b1;
      ed = x ? lane_of(m_owner) : '0;
      chk("busy", busy, m_own);
      chk("owner_id", owner_id, m_owner);
      chk("wr_en", fifo_wr_en, x);
      chk("gnt", gnt, eg);
      chk("din", fifo_din, ed);
      chk("gnt_onehot0", $onehot0(gnt), 1);
      if (fifo_wr_en) wr_cnt++;
      for (int i = 0; i < N; i++)
         if (gnt[i]) begin
            lane_cnt[i]++;
            gnt_log.push_back(i);
         end
      @(posedge clk);
      rel = 1'b0;
      if (m_own) begin
         if (x) m_beats++;
         rel = (x && (req_last[m_owner] || m_beats == BM)) || !req[m_owner];
      end
      if (!m_own || rel) begin
         m_own = 1'b0;
         for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (req[c]) begin
               m_own = 1'b1; m_owner = c; m_ptr = c; m_beats = 0;
               break;
            end
         end
      end
      #1;
   endtask

   // asserts reset with inputs still live so the check proves outputs clear asynchronously
   task automatic do_reset();
      rst_ = 1'b0;
      #1;
      m_own = 1'b0; m_owner = 0; m_ptr = N - 1; m_beats = 0;
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_din", fifo_din, 0);
      chk("rst_owner", owner_id, 0);
      req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
      @(negedge clk);
      rst_ = 1'b1;
      @(posedge clk);
      #1;
      clear_counts();
   endtask

   initial begin
      req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0; rst_ = 1'b0;
      do_reset();

      // single requester, three-word burst ending on last
      set_lane(0, 1, 8'hA1, 0); cycle();
      cycle();
      set_lane(0, 1, 8'hA2, 0); cycle();
      set_lane(0, 1, 8'hA3, 1); cycle();
      set_lane(0, 0, 8'h00, 0); cycle();
      chk("t1_writes", wr_cnt, 3);
      chk("t1_lane0", lane_cnt[0], 3);
      chk("t1_idle", busy, 0);

      // all requesting, bursts capped at BURST_MAX, no bubbles
      do_reset();
      for (int i = 0; i < N; i++) set_lane(i, 1, DW'(8'h10 + i), 0);
      cycle();
      repeat (16) cycle();
      chk("t2_writes", wr_cnt, 16);
      for (int i = 0; i < N; i++) chk("t2_lane_cnt", lane_cnt[i], 4);
      chk("t2_log_size", gnt_log.size(), 16);
      if (gnt_log.size() == 16)
         for (int j = 0; j < 16; j++) chk("t2_order", gnt_log[j], (j / 4) % N);
      cycle();
      chk("t2_wrap_owner", owner_id, 0);

      // full stalls the owner mid-burst
      do_reset();
      set_lane(2, 1, 8'h2C, 0);
      cycle(); cycle(); cycle();
      fifo_full = 1'b1;
      repeat (5) cycle();
      chk("t3_stalled_writes", wr_cnt, 2);
      chk("t3_owner_held", owner_id, 2);
      fifo_full = 1'b0;
      cycle(); cycle();
      chk("t3_lane2", lane_cnt[2], 4);
      set_lane(2, 0, 8'h00, 0); cycle(); cycle();

      // owner withdraws mid-burst
      do_reset();
      set_lane(1, 1, 8'h41, 0); set_lane(3, 1, 8'h43, 0);
      cycle(); cycle(); cycle();
      chk("t4_lane1", lane_cnt[1], 2);
      set_lane(1, 0, 8'h00, 0); cycle();
      chk("t4_no_write", wr_cnt, 2);
      chk("t4_new_owner", owner_id, 3);
      chk("t4_busy", busy, 1);
      cycle();
      chk("t4_lane3", lane_cnt[3], 1);

      // single-word bursts alternate
      do_reset();
      set_lane(0, 1, 8'h50, 1); set_lane(2, 1, 8'h52, 1);
      cycle();
      repeat (4) cycle();
      chk("t5_log_size", gnt_log.size(), 4);
      if (gnt_log.size() == 4)
         for (int j = 0; j < 4; j++) chk("t5_order", gnt_log[j], (j % 2) * 2);

      // reset mid-burst, then fresh arbitration from requester 0
      do_reset();
      set_lane(1, 1, 8'h61, 0);
      cycle(); cycle(); cycle();
      chk("t6_pre_owner", owner_id, 1);
      #2;
      do_reset();
      set_lane(0, 1, 8'h70, 0); set_lane(1, 1, 8'h71, 0);
      cycle(); cycle();
      chk("t6_first_lane0", lane_cnt[0], 1);
      chk("t6_first_owner", owner_id, 0);

      // random traffic against the model
      do_reset();
      repeat (400) begin
         req       = N'($urandom);
         req_last  = N'($urandom);
         req_data  = (N*DW)'($urandom);
         fifo_full = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
